spi_responder: RTL and testbench

SPI mode-0 responder (peripheral side), the counterpart to the team's SPI initiator and its restart timer. It oversamples the external `sclk`, `cs_n` and `mosi` pins in the system `clock` domain, deserialises MOSI into words and serialises MISO from a one-deep transmit buffer. It presents valid/ready-style word interfaces to the local logic and flags aborted frames.

---
 rtl/spi_responder_pkg.sv | 14 +
 rtl/spi_pin_sync.sv | 31 +++
 rtl/spi_responder.sv | 174 +++++++++++++++++
 tb/tb_spi_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_responder_pkg.sv
// rtl/spi_responder_pkg.sv - shared state encodings and idle pin levels for the SPI responder
package spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_ARMWAIT = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop pin synchroniser with rise/fall detect against a third copy
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder: oversampled pins, word deserialiser and
// MISO serialiser fed from a one-deep transmit buffer
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = WIDTH'(8'hFF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_error
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise_n, cs_fall_n;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_pin_sync #(.RESET_VAL(SCLK_IDLE)) u_sync_sclk (
    .clock(clock), .reset(reset), .pin(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.RESET_VAL(CS_N_IDLE)) u_sync_cs (
    .clock(clock), .reset(reset), .pin(cs_n),
    .level(cs_lvl), .rise(cs_rise_n), .fall(cs_fall_n)
  );

  spi_pin_sync #(.RESET_VAL(MOSI_IDLE)) u_sync_mosi (
    .clock(clock), .reset(reset), .pin(mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_t           state, state_nx;
  logic [1:0]       primed;
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_end;

  logic             start_frame, end_frame, load_word, shift_tx, sample;
  logic [WIDTH-1:0] next_word;

  // The synchronisers come out of reset at idle levels, so the real cs_n
  // level is only visible once primed has filled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_ARMWAIT;
      primed <= 2'b00;
    end else begin
      state  <= state_nx;
      primed <= {primed[0], 1'b1};
    end
  end

  always_comb begin
    state_nx    = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    load_word   = 1'b0;
    shift_tx    = 1'b0;
    sample      = 1'b0;
    case (state)
      ST_ARMWAIT: begin
        if (primed[1] && cs_lvl) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall_n) begin
          state_nx    = ST_SHIFT;
          start_frame = 1'b1;
          load_word   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_n) begin
          state_nx  = ST_IDLE;
          end_frame = 1'b1;
        end else begin
          sample    = sclk_rise;
          load_word = sclk_fall && word_end;
          shift_tx  = sclk_fall && !word_end;
        end
      end
      default: state_nx = ST_ARMWAIT;
    endcase
  end

  assign next_word = buf_full ? buf_data : FILL;
  assign tx_ready  = !buf_full;
  assign busy      = (state == ST_SHIFT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_full    <= 1'b0;
      buf_data    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      word_end    <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      // A write landing on a load cycle misses that load and waits for the next.
      if (load_word && buf_full) begin
        buf_full <= 1'b0;
      end else if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end

      if (load_word) begin
        tx_sr       <= next_word;
        miso        <= next_word[WIDTH-1];
        word_end    <= 1'b0;
        tx_underrun <= !buf_full;
      end else if (shift_tx) begin
        tx_sr <= tx_sr << 1;
        miso  <= tx_sr[WIDTH-2];
      end

      if (start_frame) begin
        miso_oe <= 1'b1;
        bit_cnt <= '0;
        rx_sr   <= '0;
      end

      if (sample) begin
        rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= {rx_sr[WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
          word_end <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (end_frame) begin
        miso_oe <= 1'b0;
        miso    <= 1'b0;
        if (bit_cnt != '0) frame_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed bench for spi_responder with sclk at clock/8
`timescale 1ns/1ps
module tb_spi_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_error;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_ferr = 0;

  spi_responder #(.WIDTH(8), .FILL(8'hFF)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid)    n_rxv++;
    if (tx_underrun) n_und++;
    if (frame_error) n_ferr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 40) begin
      tick();
      n++;
    end
    check_eq("push_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check_eq("tx_ready_after_xfer", 32'(tx_ready), 32'd0);
  endtask

  task automatic sclk_bit(input logic b);
    mosi = b;
    repeat (4) tick();
    sclk = 1'b1;
    repeat (4) tick();
    sclk = 1'b0;
  endtask

  // The last sclk fall and the cs_n rise are driven together; collide_at >= 0
  // raises cs_n with sclk on that bit instead.
  task automatic run_frame(input int nbits, input logic [31:0] mosi_w,
                           input int collide_at, output logic [31:0] miso_w);
    bit stop;
    stop   = 1'b0;
    miso_w = '0;
    cs_n   = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < nbits && !stop; i++) begin
      mosi = mosi_w[nbits-1-i];
      repeat (4) tick();
      if (i == 0) begin
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        check_eq("miso_oe_in_frame", 32'(miso_oe), 32'd1);
      end
      miso_w = {miso_w[30:0], miso};
      sclk = 1'b1;
      if (i == collide_at) begin
        cs_n = 1'b1;
        stop = 1'b1;
      end
      repeat (4) tick();
      sclk = 1'b0;
      if (i == nbits - 1) cs_n = 1'b1;
    end
    mosi = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mw;
    int rxv0, und0, ferr0;

    // reset values
    #2;
    check_eq("rst_miso", 32'(miso), 32'd0);
    check_eq("rst_miso_oe", 32'(miso_oe), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_error", 32'(frame_error), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();

    // single word exchange
    push(8'hA5);
    rxv0 = n_rxv; und0 = n_und; ferr0 = n_ferr;
    run_frame(8, 32'h3C, -1, mw);
    check_eq("single_miso", mw, 32'hA5);
    check_eq("single_rx_data", 32'(rx_data), 32'h3C);
    check_eq("single_rx_valid_cnt", n_rxv - rxv0, 1);
    check_eq("single_underrun_cnt", n_und - und0, 0);
    check_eq("single_ferr_cnt", n_ferr - ferr0, 0);
    check_eq("single_busy_after", 32'(busy), 32'd0);
    check_eq("single_oe_after", 32'(miso_oe), 32'd0);
    check_eq("single_miso_after", 32'(miso), 32'd0);
    check_eq("single_tx_ready_after", 32'(tx_ready), 32'd1);

    // underrun on second word
    push(8'h11);
    rxv0 = n_rxv; und0 = n_und;
    run_frame(16, 32'h1234, -1, mw);
    check_eq("underrun_miso", mw, 32'h11FF);
    check_eq("underrun_cnt", n_und - und0, 1);
    check_eq("underrun_rx_valid_cnt", n_rxv - rxv0, 2);
    check_eq("underrun_rx_data", 32'(rx_data), 32'h34);

    // back-to-back words with refill during word 1
    push(8'h11);
    rxv0 = n_rxv; und0 = n_und;
    fork
      run_frame(16, 32'hBEEF, -1, mw);
      begin : refill
        int n;
        n = 0;
        while (!tx_ready && n < 40) begin
          tick();
          n++;
        end
        check_eq("refill_ready", 32'(tx_ready), 32'd1);
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check_eq("refill_ready_drop", 32'(tx_ready), 32'd0);
      end
    join
    check_eq("b2b_miso", mw, 32'h1122);
    check_eq("b2b_rx_valid_cnt", n_rxv - rxv0, 2);
    check_eq("b2b_underrun_cnt", n_und - und0, 0);
    check_eq("b2b_rx_data", 32'(rx_data), 32'hEF);
    check_eq("b2b_tx_ready_after", 32'(tx_ready), 32'd1);

    // aborted frame after 5 bits, empty buffer
    rxv0 = n_rxv; und0 = n_und; ferr0 = n_ferr;
    run_frame(5, 32'h15, -1, mw);
    check_eq("abort_miso", mw, 32'h1F);
    check_eq("abort_ferr_cnt", n_ferr - ferr0, 1);
    check_eq("abort_rx_valid_cnt", n_rxv - rxv0, 0);
    check_eq("abort_rx_data", 32'(rx_data), 32'hEF);
    check_eq("abort_underrun_cnt", n_und - und0, 1);
    push(8'h5A);
    rxv0 = n_rxv; ferr0 = n_ferr;
    run_frame(8, 32'hC3, -1, mw);
    check_eq("post_abort_miso", mw, 32'h5A);
    check_eq("post_abort_rx_data", 32'(rx_data), 32'hC3);
    check_eq("post_abort_rx_valid_cnt", n_rxv - rxv0, 1);
    check_eq("post_abort_ferr_cnt", n_ferr - ferr0, 0);

    // reset mid-frame, released with cs_n still low
    push(8'h77);
    cs_n = 1'b0;
    repeat (4) tick();
    sclk_bit(1'b1);
    sclk_bit(1'b0);
    sclk_bit(1'b1);
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_miso", 32'(miso), 32'd0);
    check_eq("midrst_miso_oe", 32'(miso_oe), 32'd0);
    check_eq("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    rxv0 = n_rxv; ferr0 = n_ferr;
    repeat (9) sclk_bit(1'b1);
    check_eq("armwait_busy", 32'(busy), 32'd0);
    check_eq("armwait_oe", 32'(miso_oe), 32'd0);
    check_eq("armwait_rx_valid_cnt", n_rxv - rxv0, 0);
    check_eq("armwait_rx_data", 32'(rx_data), 32'd0);
    cs_n = 1'b1;
    repeat (10) tick();
    check_eq("armwait_ferr_cnt", n_ferr - ferr0, 0);
    push(8'h96);
    rxv0 = n_rxv;
    run_frame(8, 32'h69, -1, mw);
    check_eq("post_reset_miso", mw, 32'h96);
    check_eq("post_reset_rx_data", 32'(rx_data), 32'h69);
    check_eq("post_reset_rx_valid_cnt", n_rxv - rxv0, 1);

    // cs_n and sclk rising together on bit 7 of 8
    rxv0 = n_rxv; ferr0 = n_ferr;
    run_frame(8, 32'hFF, 6, mw);
    check_eq("collide_ferr_cnt", n_ferr - ferr0, 1);
    check_eq("collide_rx_valid_cnt", n_rxv - rxv0, 0);
    check_eq("collide_rx_data", 32'(rx_data), 32'h69);
    check_eq("collide_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
